// File: rtl/maq_enc_veda_pkg.sv
// Shared state codes and timer sizing for the fill/seal station.
// tipo decoding on the display side relies on these exact codes.
package maq_enc_veda_pkg;

    typedef enum logic [2:0] {
        SEM_GARRAFA    = 3'b000,
        GARRAFA_VAZIA  = 3'b001,
        ENCHENDO       = 3'b010,
        VEDANDO        = 3'b011,
        GARRAFA_PRONTA = 3'b100,
        FALHA          = 3'b101
    } estado_t;

    // Bits needed to count up to the larger of the two timeouts.
    function automatic int tmr_w(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/temporizador_estado.sv
// Per-state watchdog: counts cycles spent in a timed state and flags
// when the count reaches the limit chosen by the current state.
module temporizador_estado #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limite,
    output logic         fim
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Restart on every state change and whenever the state is not timed.
    always_comb begin
        cnt_d = cnt_q;
        if (clr || !en) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fim = en && (cnt_q == limite);

endmodule

// File: rtl/maq_enc_veda_temporizada.sv
// Single-station fill/seal controller with fill/seal watchdogs,
// latched fault with operator acknowledge and bottle/fault counters.
module maq_enc_veda_temporizada
    import maq_enc_veda_pkg::*;
#(
    parameter int FILL_TIMEOUT = 16,
    parameter int SEAL_TIMEOUT = 8,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             EN,
    input  logic             PG,
    input  logic             CH,
    input  logic             RO,
    input  logic             ACK,
    output logic             EV,
    output logic             VE,
    output logic             GC,
    output logic             FL,
    output logic [2:0]       tipo,
    output logic [CNT_W-1:0] cont,
    output logic [CNT_W-1:0] cont_falha
);

    localparam int TW = tmr_w(FILL_TIMEOUT, SEAL_TIMEOUT);
    localparam logic [TW-1:0] LIM_FILL = TW'(FILL_TIMEOUT - 1);
    localparam logic [TW-1:0] LIM_SEAL = TW'(SEAL_TIMEOUT - 1);

    estado_t          estado_q, estado_d;
    logic             ev_q, ev_d;
    logic             ve_q, ve_d;
    logic             gc_q, gc_d;
    logic             fl_q, fl_d;
    logic [CNT_W-1:0] cont_q, cont_d;
    logic [CNT_W-1:0] falha_q, falha_d;

    logic             tmr_en;
    logic             tmr_clr;
    logic             tmr_fim;
    logic [TW-1:0]    tmr_lim;

    assign tmr_en  = (estado_q == ENCHENDO) || (estado_q == VEDANDO);
    assign tmr_lim = (estado_q == VEDANDO) ? LIM_SEAL : LIM_FILL;
    assign tmr_clr = (estado_d != estado_q);

    temporizador_estado #(
        .W (TW)
    ) u_tmr (
        .clk    (clk),
        .reset  (reset),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .limite (tmr_lim),
        .fim    (tmr_fim)
    );

    // Next state; sensor events outrank the watchdog in timed states.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            SEM_GARRAFA: begin
                if (PG && !CH) estado_d = GARRAFA_VAZIA;
            end
            GARRAFA_VAZIA: begin
                if (!PG)     estado_d = SEM_GARRAFA;
                else if (EN) estado_d = ENCHENDO;
            end
            ENCHENDO: begin
                if (!PG)          estado_d = FALHA;
                else if (CH)      estado_d = VEDANDO;
                else if (tmr_fim) estado_d = FALHA;
            end
            VEDANDO: begin
                if (!PG)          estado_d = FALHA;
                else if (RO)      estado_d = GARRAFA_PRONTA;
                else if (tmr_fim) estado_d = FALHA;
            end
            GARRAFA_PRONTA: begin
                if (!PG) estado_d = SEM_GARRAFA;
            end
            FALHA: begin
                if (ACK && !PG) estado_d = SEM_GARRAFA;
            end
            default: estado_d = SEM_GARRAFA;
        endcase
    end

    // Outputs decoded from the next state so they register with it;
    // counters bump only on the edge entering their state.
    always_comb begin
        ev_d    = (estado_d == ENCHENDO);
        ve_d    = (estado_d == VEDANDO);
        gc_d    = (estado_d == GARRAFA_PRONTA);
        fl_d    = (estado_d == FALHA);
        cont_d  = cont_q;
        falha_d = falha_q;
        if (gc_d && (estado_q != GARRAFA_PRONTA)) begin
            cont_d = cont_q + 1'b1;
        end
        if (fl_d && (estado_q != FALHA) && (falha_q != '1)) begin
            falha_d = falha_q + 1'b1;
        end
    end

    // State, registered outputs and counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q <= SEM_GARRAFA;
            ev_q     <= 1'b0;
            ve_q     <= 1'b0;
            gc_q     <= 1'b0;
            fl_q     <= 1'b0;
            cont_q   <= '0;
            falha_q  <= '0;
        end else begin
            estado_q <= estado_d;
            ev_q     <= ev_d;
            ve_q     <= ve_d;
            gc_q     <= gc_d;
            fl_q     <= fl_d;
            cont_q   <= cont_d;
            falha_q  <= falha_d;
        end
    end

    assign EV         = ev_q;
    assign VE         = ve_q;
    assign GC         = gc_q;
    assign FL         = fl_q;
    assign tipo       = estado_q;
    assign cont       = cont_q;
    assign cont_falha = falha_q;

endmodule
